sevenseg_capture: RTL
=====================

# sevenseg_capture

Receiver for the multiplexed seven-segment display bus. It samples the active-low anode (`an`) and segment (`seg`) lines that the display driver produces, decodes each strobed digit back to BCD, and assembles complete four-digit frames. It publishes a stable frame through a valid/ready handshake. It sits on the board-test and self-check path alongside the stopwatch display driver, letting a checker or host read back the time actually shown.

## Interface
- `SETTLE_CYCLES`, default 4: number of `msclk` cycles `{an,seg}` must hold unchanged before the block samples it.
- `STABLE_FRAMES`, default 2: number of consecutive identical complete frames required before publishing.
- `BLANK_TIMEOUT`, default 1000: number of consecutive cycles of `an==4'b1111` that assert `blank`.
- `msclk`, in, 1: system clock. One clock domain only.
- `rst`, in, 1: reset, asynchronous and active-high.
- `an`, in, 4: anode lines, active-low, one-hot. 1110 selects digit 0, 0111 selects digit 3.
- `seg`, in, 8: segment lines, active-low. Bit 7 is dp, bits 6:0 are g..a.
- `digits`, out, 16: published frame as {d3,d2,d1,d0}, 4-bit codes each. Code 0–9 is BCD, 4'hF is a blank digit.
- `dp`, out, 4: published decimal points, one per digit.
- `out_valid`, out, 1: `digits`/`dp` hold a new frame.
- `out_ready`, in, 1: consumer accepts the frame.
- `blank`, out, 1: display is blanked (blink-off phase).
- `err`, out, 1: one-cycle pulse on an illegal sample.
- `overrun`, out, 1: sticky flag; a frame was dropped because the consumer had not accepted the previous one.

## Operation
- Input stage: `an` and `seg` each pass through a 2-flop synchronizer.
- Sampling FSM:
  - WAIT: go to SETTLING whenever synchronized `{an,seg}` differs from the previous cycle.
  - SETTLING: the counter restarts on any change. When the counter reaches `SETTLE_CYCLES`, take exactly one sample and go to SAMPLED.
  - SAMPLED: return to SETTLING on the next change.
- Anode decode:
  - One-hot-low selects the position.
  - 1111 means no digit is strobed: no sample is taken, and the blank counter is fed.
  - Any other pattern is illegal.
- Segment decode on `seg[6:0]`:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 1111111→4'hF (blank digit).
  - Anything else is illegal.
- Illegal sample: `err` pulses for one cycle, the frame in assembly is discarded (seen-mask cleared), and the match count resets to 0.
- Frame assembly:
  - Each legal sample writes its position in the shadow frame and sets its bit in the seen-mask.
  - A repeated position overwrites the earlier value.
  - When the mask reaches 4'b1111, the frame is complete and the mask clears.
- Stability check on a complete frame:
  - If it equals the previous complete frame, the match count increments (saturating at `STABLE_FRAMES`). Otherwise the match count is set to 1.
  - When the match count reaches `STABLE_FRAMES` and the frame differs from the currently published frame, publish it. The first stable frame after reset is always published.
- Publish:
  - If `out_valid`=0: load `digits`/`dp` and set `out_valid`.
  - If `out_valid`=1 and `out_ready`=0 in that cycle: drop the frame, keep `digits` unchanged, and set `overrun`.
- Handshake:
  - `out_valid` holds until a cycle with `out_valid && out_ready`; it clears on the next edge.
  - A publish in the same cycle as acceptance loads the new frame and keeps `out_valid`=1.
- `blank`:
  - Sets after `BLANK_TIMEOUT` consecutive 1111 cycles, or when a complete frame is all 4'hF.
  - Clears on the first legal non-F digit sample.
- Counter widths use $clog2 of the parameter. Counters saturate; none of them wrap.

## Timing
- Reset values: `digits`=16'hFFFF, `dp`=0, `out_valid`=0, `blank`=0, `err`=0, `overrun`=0. The FSM resets to WAIT, and the mask and match count reset to 0.
- A reset asserted mid-frame discards all partial state immediately (asynchronous).
- Latency, pin to sample: 2 sync cycles + `SETTLE_CYCLES` cycles.
- Latency, sample of the completing digit to `out_valid`: 2 cycles (compare, then publish).
- `err` is asserted in the cycle after the illegal sample.
- `overrun` clears only on `rst`.

## Configuration
- `SEVENSEG_CAPTURE_DP_EN` defined: `seg[7]` is captured per digit, it takes part in the frame comparison, and it drives `dp`.
- Not defined: `seg[7]` is ignored, `dp` is tied to 4'b0000, and dp differences never affect the stability check.

## Test plan
- Stable display: drive 12:34 as digits 4,3,2,1 on positions 0–3, each held 20 cycles, 3 rotations. Required: `digits`=16'h1234 and `out_valid`=1 after the second complete frame; `err`=0.
- Handshake and overrun: hold `out_ready`=0, publish 12:34, then display 12:35 stable. Required: `digits` stays 16'h1234 and `overrun`=1. Then pulse `out_ready`. Required: `out_valid`=0 on the next cycle.
- Glitch rejection: insert `seg` changes of 2 cycles' duration within a digit. Required: no sample is taken from the glitch value and the published value is unchanged.
- Illegal input: `an`=4'b1100 and `seg`=7'b1010101 on separate occasions. Required: one `err` pulse each, and no publish until 2 fresh clean frames.
- Blink: `an`=4'b1111 for 1000 cycles. Required: `blank`=1. Then a legal digit 7. Required: `blank`=0.
- Reset mid-frame: assert `rst` after 2 digits. Required: outputs at reset values immediately, and the next publish only after 2 full new frames.

Source files
------------

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - seven-segment bus receiver; optional dp capture via SEVENSEG_CAPTURE_DP_EN
module sevenseg_capture #(
   parameter int SETTLE_CYCLES = 4,
   parameter int STABLE_FRAMES = 2,
   parameter int BLANK_TIMEOUT = 1000
) (
   input  logic        msclk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [7:0]  seg,
   output logic [15:0] digits,
   output logic [3:0]  dp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        blank,
   output logic        err,
   output logic        overrun
);

   localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
   localparam int MC_W = $clog2(STABLE_FRAMES + 1);
   localparam int BC_W = $clog2(BLANK_TIMEOUT + 1);
   localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [SC_W-1:0] SETTLE_MAX  = SC_W'(SETTLE_CYCLES);
   localparam logic [MC_W-1:0] MATCH_MAX   = MC_W'(STABLE_FRAMES);
   localparam logic [BC_W-1:0] BLANK_LAST  = BC_W'(BLANK_TIMEOUT - 1);
   localparam logic [BC_W-1:0] BLANK_MAX   = BC_W'(BLANK_TIMEOUT);

   typedef enum logic [1:0] {ST_WAIT, ST_SETTLING, ST_SAMPLED} state_t;

   logic [3:0]      r_an_s1, r_an_s2;
   logic [7:0]      r_seg_s1, r_seg_s2;
   logic [11:0]     w_bus, r_prev;
   logic            w_change, w_take;
   state_t          r_state, w_next;
   logic [SC_W-1:0] r_settle_cnt;

   logic            w_an_idle, w_an_ok, w_seg_ok, w_legal;
   logic [1:0]      w_pos;
   logic [3:0]      w_code;
   logic [15:0]     w_new_digits;
   logic [3:0]      w_new_dp, w_new_mask;

   logic [15:0]     r_shadow, r_cmp_digits, r_last_digits, r_digits;
   logic [3:0]      r_shadow_dp, r_cmp_dp, r_last_dp, r_dp, r_mask;
   logic            r_cmp_valid, r_err, r_valid, r_overrun, r_pub_any, r_blank;
   logic [MC_W-1:0] r_match, w_match_next;
   logic            w_same, w_publish;
   logic [BC_W-1:0] r_blank_cnt;

   // Two-flop synchronizers; reset to the idle (all-off) bus level
   always_ff @(posedge msclk or posedge rst) begin
      if (rst) begin
         r_an_s1  <= 4'hF;
         r_an_s2  <= 4'hF;
         r_seg_s1 <= 8'hFF;
         r_seg_s2 <= 8'hFF;
      end else begin
         r_an_s1  <= an;
         r_an_s2  <= r_an_s1;
         r_seg_s1 <= seg;
         r_seg_s2 <= r_seg_s1;
      end
   end

`ifdef SEVENSEG_CAPTURE_DP_EN
   assign w_bus = {r_an_s2, r_seg_s2};
`else
   // dp line is masked so its toggling never restarts settling
   logic w_unused_dp;
   assign w_unused_dp = r_seg_s2[7];
   assign w_bus = {r_an_s2, 1'b1, r_seg_s2[6:0]};
`endif

   assign w_change  = (w_bus != r_prev);
   assign w_an_idle = (w_bus[11:8] == 4'b1111);

   // Previous-cycle bus value for change detection
   always_ff @(posedge msclk or posedge rst) begin
      if (rst) r_prev <= 12'hFFF;
      else     r_prev <= w_bus;
   end

   // Sampling FSM state register
   always_ff @(posedge msclk or posedge rst) begin
      if (rst) r_state <= ST_WAIT;
      else     r_state <= w_next;
   end

   // Sampling FSM next state; w_take fires once per settled bus value
   always_comb begin
      w_next = r_state;
      w_take = 1'b0;
      case (r_state)
         ST_WAIT:     if (w_change) w_next = ST_SETTLING;
         ST_SETTLING: if (!w_change && r_settle_cnt == SETTLE_LAST) begin
                         w_take = 1'b1;
                         w_next = ST_SAMPLED;
                      end
         ST_SAMPLED:  if (w_change) w_next = ST_SETTLING;
         default:     w_next = ST_WAIT;
      endcase
   end

   // Settle counter restarts on any change and counts only while settling
   always_ff @(posedge msclk or posedge rst) begin
      if (rst)                                     r_settle_cnt <= '0;
      else if (w_change || r_state != ST_SETTLING) r_settle_cnt <= '0;
      else if (r_settle_cnt < SETTLE_MAX)          r_settle_cnt <= r_settle_cnt + 1'b1;
   end

   // Anode/segment decode and the shadow frame as it would look after this sample
   always_comb begin
      w_pos    = 2'd0;
      w_an_ok  = 1'b1;
      w_seg_ok = 1'b1;
      w_code   = 4'hF;
      case (w_bus[11:8])
         4'b1110: w_pos = 2'd0;
         4'b1101: w_pos = 2'd1;
         4'b1011: w_pos = 2'd2;
         4'b0111: w_pos = 2'd3;
         default: w_an_ok = 1'b0;
      endcase
      case (w_bus[6:0])
         7'b1000000: w_code = 4'd0;
         7'b1111001: w_code = 4'd1;
         7'b0100100: w_code = 4'd2;
         7'b0110000: w_code = 4'd3;
         7'b0011001: w_code = 4'd4;
         7'b0010010: w_code = 4'd5;
         7'b0000010: w_code = 4'd6;
         7'b1111000: w_code = 4'd7;
         7'b0000000: w_code = 4'd8;
         7'b0010000: w_code = 4'd9;
         7'b1111111: w_code = 4'hF;
         default:    w_seg_ok = 1'b0;
      endcase
      w_legal      = w_an_ok && w_seg_ok;
      w_new_digits = r_shadow;
      w_new_digits[{w_pos, 2'b00} +: 4] = w_code;
      w_new_dp     = r_shadow_dp;
`ifdef SEVENSEG_CAPTURE_DP_EN
      w_new_dp[w_pos] = ~w_bus[7];
`endif
      w_new_mask   = r_mask | (4'b0001 << w_pos);
   end

   // Frame assembly: legal samples fill the shadow, illegal ones discard it
   always_ff @(posedge msclk or posedge rst) begin
      if (rst) begin
         r_shadow     <= 16'hFFFF;
         r_shadow_dp  <= 4'h0;
         r_mask       <= 4'h0;
         r_cmp_valid  <= 1'b0;
         r_cmp_digits <= 16'hFFFF;
         r_cmp_dp     <= 4'h0;
         r_err        <= 1'b0;
      end else begin
         r_cmp_valid <= 1'b0;
         r_err       <= 1'b0;
         if (w_take && !w_an_idle) begin
            if (w_legal) begin
               r_shadow    <= w_new_digits;
               r_shadow_dp <= w_new_dp;
               if (w_new_mask == 4'b1111) begin
                  r_mask       <= 4'h0;
                  r_cmp_valid  <= 1'b1;
                  r_cmp_digits <= w_new_digits;
                  r_cmp_dp     <= w_new_dp;
               end else begin
                  r_mask <= w_new_mask;
               end
            end else begin
               r_err  <= 1'b1;
               r_mask <= 4'h0;
            end
         end
      end
   end

   // Stability decision for the frame in the compare stage
   always_comb begin
      w_same       = (r_cmp_digits == r_last_digits) && (r_cmp_dp == r_last_dp);
      w_match_next = MC_W'(1);
      if (w_same) w_match_next = (r_match >= MATCH_MAX) ? r_match : r_match + 1'b1;
      w_publish    = (w_match_next == MATCH_MAX) &&
                     (!r_pub_any || r_cmp_digits != r_digits || r_cmp_dp != r_dp);
   end

   // Compare, publish and handshake; a full output register drops the frame
   always_ff @(posedge msclk or posedge rst) begin
      if (rst) begin
         r_last_digits <= 16'hFFFF;
         r_last_dp     <= 4'h0;
         r_match       <= '0;
         r_pub_any     <= 1'b0;
         r_digits      <= 16'hFFFF;
         r_dp          <= 4'h0;
         r_valid       <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         if (r_valid && out_ready) r_valid <= 1'b0;
         if (r_cmp_valid) begin
            r_last_digits <= r_cmp_digits;
            r_last_dp     <= r_cmp_dp;
            r_match       <= w_match_next;
            if (w_publish) begin
               if (!r_valid || out_ready) begin
                  r_digits  <= r_cmp_digits;
                  r_dp      <= r_cmp_dp;
                  r_valid   <= 1'b1;
                  r_pub_any <= 1'b1;
               end else begin
                  r_overrun <= 1'b1;
               end
            end
         end
         if (r_err) r_match <= '0;
      end
   end

   // Blank detection: long idle anodes or an all-blank frame; cleared by a lit digit
   always_ff @(posedge msclk or posedge rst) begin
      if (rst) begin
         r_blank_cnt <= '0;
         r_blank     <= 1'b0;
      end else begin
         if (w_an_idle) begin
            if (r_blank_cnt < BLANK_MAX) r_blank_cnt <= r_blank_cnt + 1'b1;
            if (r_blank_cnt >= BLANK_LAST) r_blank <= 1'b1;
         end else begin
            r_blank_cnt <= '0;
         end
         if (w_take && !w_an_idle && w_legal) begin
            if (w_code != 4'hF)
               r_blank <= 1'b0;
            else if (w_new_mask == 4'b1111 && w_new_digits == 16'hFFFF)
               r_blank <= 1'b1;
         end
      end
   end

   assign digits    = r_digits;
   assign dp        = r_dp;
   assign out_valid = r_valid;
   assign blank     = r_blank;
   assign err       = r_err;
   assign overrun   = r_overrun;

endmodule
